byte_lsu: RTL and testbench

- Load/store unit between the CORE data-side request and a byte-wide (D=8) Memory write/read port.
- Turns one RV32I load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into 1, 2 or 4 sequential single-byte memory cycles.
- Loads: assembles the bytes little-endian and sign- or zero-extends the result.
- Misaligned or illegal requests get an error response and make no memory access.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_extend.sv | 19 +
 rtl/byte_lsu.sv | 100 ++++++++++
 tb/tb_byte_lsu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and helpers for the byte-wide load/store unit.
// Contents: state_t (ST_IDLE/ST_XFER/ST_RESP), F3_* load/store size codes,
//           size_of() byte count, req_bad() legality/alignment test.
package lsu_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    endfunction

    // Illegal funct3 for the direction, or address not aligned to the access size.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        logic [2:0] n;
        legal = we ? f3 inside {F3_B, F3_H, F3_W} : f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        n = size_of(f3);
        return !legal || (n == 3'd2 && a[0]) || (n == 3'd4 && a != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of an assembled little-endian load word.
// Ports: funct3 (load type), word (assembled bytes, byte 0 in [7:0]),
//        result (extended 32-bit load value; LW passes word through).
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] result
);

    always_comb begin
        result = funct3 == F3_B  ? {{24{word[7]}}, word[7:0]} :
                 funct3 == F3_BU ? {24'h0, word[7:0]} :
                 funct3 == F3_H  ? {{16{word[15]}}, word[15:0]} :
                 funct3 == F3_HU ? {16'h0, word[15:0]} : word;
    end

endmodule

// File: rtl/byte_lsu.sv
// byte_lsu: splits an RV32I load/store into sequential single-byte memory cycles.
// Ports: clk, reset (async, active-low);
//        req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata (core request);
//        rsp_valid/rsp_rdata/rsp_err (one-cycle response strobe, data held after);
//        mem_addr/mem_wdata/mem_we/mem_rdata (byte-wide memory, combinational read).
module byte_lsu
    import lsu_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);

    state_t state, state_d;
    logic we_q, ready_q, accept, bad, last;
    logic [2:0] f3_q;
    logic [1:0] idx;
    logic [AW-1:0] addr_q;
    logic [31:0] wdata_q, asm_q, asm_d, ext;
    logic unused_addr;

    assign unused_addr = ^req_addr[31:AW];

    lsu_extend u_ext (.funct3(f3_q), .word(asm_d), .result(ext));

    always_comb begin
        accept = req_valid && ready_q;
        bad = req_bad(req_we, req_funct3, req_addr[1:0]);
        last = {1'b0, idx} == size_of(f3_q) - 3'd1;
        // Merge the byte being read this cycle so the response can use it at the same edge.
        asm_d = asm_q;
        asm_d[{idx, 3'b000} +: 8] = mem_rdata;
        state_d = state == ST_IDLE ? (accept ? (bad ? ST_RESP : ST_XFER) : ST_IDLE) :
                  state == ST_XFER ? (last ? ST_RESP : ST_XFER) : ST_IDLE;
    end

    // Memory side is driven only from latched request state, never from req_*.
    assign req_ready = ready_q;
    assign mem_we    = state == ST_XFER && we_q;
    assign mem_addr  = addr_q + AW'(idx);
    assign mem_wdata = wdata_q[{idx, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            asm_q     <= 32'h0;
            idx       <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            ready_q   <= state_d == ST_IDLE;
            rsp_valid <= state_d == ST_RESP;
            if (accept) begin
                we_q <= req_we;
                f3_q <= req_funct3;
                if (bad) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                end else begin
                    // Address/data only latched for legal requests so mem_* hold outside XFER.
                    addr_q  <= req_addr[AW-1:0];
                    wdata_q <= req_wdata;
                    idx     <= 2'd0;
                end
            end
            if (state == ST_XFER) begin
                if (!we_q)
                    asm_q <= asm_d;
                if (last) begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= we_q ? 32'h0 : ext;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_lsu.sv
// tb_byte_lsu: directed + random checks of byte_lsu against a byte-array reference model.
module tb_byte_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    byte_lsu #(.AW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    function automatic int size_n(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic is_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic ok;
        n = size_n(f3);
        ok = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return !ok || (a % n) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 0;
        n = size_n(f3);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 256]) << (8 * i));
        if (n == 1 && !f3[2]) v = (v ^ 32'h80) - 32'h80;
        if (n == 2 && !f3[2]) v = (v ^ 32'h8000) - 32'h8000;
        return v;
    endfunction

    // Issues one request and checks every cycle until the unit is idle again.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n, lat, w;
        logic err;
        logic [31:0] exp_rd;
        err = is_err(we, f3, a);
        n = err ? 0 : size_n(f3);
        lat = n + 1;
        exp_rd = (err || we) ? 32'h0 : load_val(f3, a);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            chk("busy_ready", 32'(req_ready), 32'h0);
            if (k <= n) begin
                chk("xfer_we", 32'(mem_we), 32'(we));
                chk("xfer_addr", 32'(mem_addr), (a + k - 1) % 256);
                if (we) chk("xfer_wdata", 32'(mem_wdata), (wd >> (8 * (k - 1))) & 32'hff);
                chk("xfer_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                chk("rsp_we", 32'(mem_we), 32'h0);
                chk("rsp_valid", 32'(rsp_valid), 32'h1);
                chk("rsp_err", 32'(rsp_err), 32'(err));
                chk("rsp_rdata", rsp_rdata, exp_rd);
            end
        end
        if (we && !err)
            for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = 8'((wd >> (8 * i)) & 32'hff);
        @(posedge clk); #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post_ready", 32'(req_ready), 32'h1);
        chk("hold_rdata", rsp_rdata, exp_rd);
    endtask

    initial begin
        int diffs;
        reset = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("first_ready", 32'(req_ready), 32'h1);

        do_req(1'b1, 3'b010, 32'd4, 32'h1234abcd);
        poke(8'd8, 8'hf0);
        do_req(1'b0, 3'b000, 32'd8, 32'h0);
        do_req(1'b0, 3'b100, 32'd8, 32'h0);
        poke(8'd2, 8'h01);
        poke(8'd3, 8'h80);
        do_req(1'b0, 3'b001, 32'd2, 32'h0);
        do_req(1'b0, 3'b101, 32'd2, 32'h0);
        do_req(1'b0, 3'b010, 32'd6, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'hdeadbeef);
        do_req(1'b1, 3'b010, 32'h1fc, 32'h89abcdef);
        do_req(1'b1, 3'b000, 32'h30, 32'h7777775a);
        do_req(1'b0, 3'b100, 32'h30, 32'h0);
        do_req(1'b0, 3'b010, 32'hfc, 32'h0);

        // Reset asserted while byte 2 of a word store is on the bus.
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h40;
        req_wdata = 32'h44332211;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_we", 32'(mem_we), 32'h1);
        chk("mid_addr", 32'(mem_addr), 32'h42);
        reset = 1'b0;
        #1;
        chk("abort_we", 32'(mem_we), 32'h0);
        chk("abort_rsp", 32'(rsp_valid), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h0);
        ref_mem[8'h40] = 8'h11;
        ref_mem[8'h41] = 8'h22;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 32'(req_ready), 32'h1);
        chk("rel_rsp", 32'(rsp_valid), 32'h0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] ra;
            ra = (t % 3 == 0) ? ($urandom & 32'hfffffffc) : $urandom;
            do_req(1'($urandom), 3'($urandom_range(0, 7)), ra, $urandom);
        end

        #1;
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
